// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC register with next-PC selection, stall/flush control,
// a circular return-address stack that checks JR-return targets, and
// performance counters for redirects and RAS misses.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          RAS_DEPTH  = 4,
    parameter int          DELAY_SLOT = 1,
    parameter int          CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [2:0]                   npc_op,
    input  logic                         br_taken,
    input  logic [25:0]                  imm26,
    input  logic [31:0]                  pc_d,
    input  logic [31:0]                  jreg,
    input  logic                         exc_req,
    input  logic                         eret,
    input  logic [31:0]                  epc,
    output logic [31:0]                  pc_f,
    output logic [31:0]                  link_d,
    output logic                         flush_f,
    output logic                         adel_f,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_mispredict,
    output logic [CNT_W-1:0]             perf_redirect,
    output logic [CNT_W-1:0]             perf_ras_miss
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] RAS_FULL = (PTR_W+1)'(RAS_DEPTH);

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_B    = 3'd1;
    localparam logic [2:0] OP_J    = 3'd2;
    localparam logic [2:0] OP_JAL  = 3'd3;
    localparam logic [2:0] OP_JR   = 3'd4;
    localparam logic [2:0] OP_JRET = 3'd5;

    logic [31:0]      pc_q, pc_d_nxt;
    logic [31:0]      ras_q [RAS_DEPTH];
    logic [31:0]      ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [PTR_W:0]   ras_cnt_q, ras_cnt_d;
    logic             mispred_q, mispred_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [31:0]      pc_d_plus4;
    logic [31:0]      br_target;
    logic [31:0]      j_target;
    logic [31:0]      redir_target;
    logic             redirect;
    logic             d_stage_ok;
    logic [PTR_W-1:0] ptr_top;
    logic             ras_miss;

    // Target computation and redirect decode from the D-stage instruction.
    always_comb begin
        pc_d_plus4   = pc_d + 32'd4;
        br_target    = pc_d_plus4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};
        j_target     = {pc_d_plus4[31:28], imm26, 2'b00};
        redirect     = 1'b0;
        redir_target = pc_d_plus4;
        case (npc_op)
            OP_B: begin
                redirect     = br_taken;
                redir_target = br_target;
            end
            OP_J, OP_JAL: begin
                redirect     = 1'b1;
                redir_target = j_target;
            end
            OP_JR, OP_JRET: begin
                redirect     = 1'b1;
                redir_target = jreg;
            end
            default: begin
                redirect     = 1'b0;
                redir_target = pc_d_plus4;
            end
        endcase
    end

    // Next-PC priority: exception > eret > stall > redirect > sequential.
    always_comb begin
        if (exc_req) begin
            pc_d_nxt = EXC_VECTOR;
        end else if (eret) begin
            pc_d_nxt = epc;
        end else if (stall) begin
            pc_d_nxt = pc_q;
        end else if (redirect) begin
            pc_d_nxt = redir_target;
        end else begin
            pc_d_nxt = pc_q + 32'd4;
        end
    end

    // RAS push/pop/check and counter updates; only a live D-stage op has side effects.
    always_comb begin
        d_stage_ok  = !stall && !exc_req && !eret;
        ras_d       = ras_q;
        ras_ptr_d   = ras_ptr_q;
        ras_cnt_d   = ras_cnt_q;
        redir_cnt_d = redir_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        ras_miss    = 1'b0;
        ptr_top     = ras_ptr_q - 1'b1;
        if (d_stage_ok) begin
            if (redirect) begin
                redir_cnt_d = redir_cnt_q + 1'b1;
            end
            if (npc_op == OP_JAL) begin
                // Circular push: when full, the oldest entry is overwritten.
                ras_d[ras_ptr_q] = link_d;
                ras_ptr_d        = ras_ptr_q + 1'b1;
                ras_cnt_d        = (ras_cnt_q == RAS_FULL) ? RAS_FULL : ras_cnt_q + 1'b1;
            end else if (npc_op == OP_JRET) begin
                if (ras_cnt_q == '0) begin
                    ras_miss = 1'b1;
                end else begin
                    ras_miss  = (ras_q[ptr_top] != jreg);
                    ras_ptr_d = ptr_top;
                    ras_cnt_d = ras_cnt_q - 1'b1;
                end
            end
            if (ras_miss) begin
                miss_cnt_d = miss_cnt_q + 1'b1;
            end
        end
        mispred_d = ras_miss;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            ras_ptr_q   <= '0;
            ras_cnt_q   <= '0;
            mispred_q   <= 1'b0;
            redir_cnt_q <= '0;
            miss_cnt_q  <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q        <= pc_d_nxt;
            ras_ptr_q   <= ras_ptr_d;
            ras_cnt_q   <= ras_cnt_d;
            mispred_q   <= mispred_d;
            redir_cnt_q <= redir_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= ras_d[i];
            end
        end
    end

    assign link_d         = pc_d + 32'd8;
    assign flush_f        = exc_req || eret || (redirect && !stall && (DELAY_SLOT == 0));
    assign pc_f           = pc_q;
    assign adel_f         = (pc_q[1:0] != 2'b00);
    assign ras_count      = ras_cnt_q;
    assign ras_mispredict = mispred_q;
    assign perf_redirect  = redir_cnt_q;
    assign perf_ras_miss  = miss_cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (delay-slot instance plus a
// DELAY_SLOT=0 instance sharing the same stimulus).
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  npc_op;
    logic        br_taken;
    logic [25:0] imm26;
    logic [31:0] pc_d;
    logic [31:0] jreg;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;

    logic [31:0] pc_f, link_d;
    logic        flush_f, adel_f, ras_mispredict;
    logic [2:0]  ras_count;
    logic [31:0] perf_redirect, perf_ras_miss;

    logic [31:0] n_pc_f, n_link_d;
    logic        n_flush_f, n_adel_f, n_ras_mispredict;
    logic [2:0]  n_ras_count;
    logic [31:0] n_perf_redirect, n_perf_ras_miss;

    int tests_run = 0;
    int tests_failed = 0;

    pc_fetch_unit #(
        .RESET_PC(32'h0000_3000), .EXC_VECTOR(32'h0000_4180),
        .RAS_DEPTH(4), .DELAY_SLOT(1), .CNT_W(32)
    ) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .br_taken(br_taken),
        .imm26(imm26), .pc_d(pc_d), .jreg(jreg), .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc_f(pc_f), .link_d(link_d), .flush_f(flush_f), .adel_f(adel_f),
        .ras_count(ras_count), .ras_mispredict(ras_mispredict),
        .perf_redirect(perf_redirect), .perf_ras_miss(perf_ras_miss)
    );

    pc_fetch_unit #(
        .RESET_PC(32'h0000_3000), .EXC_VECTOR(32'h0000_4180),
        .RAS_DEPTH(4), .DELAY_SLOT(0), .CNT_W(32)
    ) u_dut_nds (
        .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .br_taken(br_taken),
        .imm26(imm26), .pc_d(pc_d), .jreg(jreg), .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc_f(n_pc_f), .link_d(n_link_d), .flush_f(n_flush_f), .adel_f(n_adel_f),
        .ras_count(n_ras_count), .ras_mispredict(n_ras_mispredict),
        .perf_redirect(n_perf_redirect), .perf_ras_miss(n_perf_ras_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; npc_op = 3'd0; br_taken = 1'b0; imm26 = '0;
        pc_d = '0; jreg = '0; exc_req = 1'b0; eret = 1'b0; epc = '0;
        step(); step();
        tests_run++;
        if (pc_f !== 32'h3000) begin
            tests_failed++; $display("FAIL reset_pc: got %h expected %h", pc_f, 32'h3000);
        end
        tests_run++;
        if (ras_count !== 3'd0 || ras_mispredict !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ras: count %0d mispred %b expected 0 0", ras_count, ras_mispredict);
        end
        tests_run++;
        if (perf_redirect !== 32'd0 || perf_ras_miss !== 32'd0) begin
            tests_failed++; $display("FAIL reset_counters: redirect %0d miss %0d expected 0 0", perf_redirect, perf_ras_miss);
        end
        reset = 1'b0;
    endtask

    task automatic test_seq();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h3004; exp_pc[1] = 32'h3008; exp_pc[2] = 32'h300C;
        npc_op = 3'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (pc_f !== exp_pc[i]) begin
                tests_failed++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc_f, exp_pc[i]);
            end
        end
        tests_run++;
        if (perf_redirect !== 32'd0) begin
            tests_failed++; $display("FAIL seq_no_count: got %0d expected 0", perf_redirect);
        end
    endtask

    task automatic test_branch();
        npc_op = 3'd1; pc_d = 32'h3004; imm26 = 26'h000FFFF; br_taken = 1'b1;
        #1;
        tests_run++;
        if (flush_f !== 1'b0 || n_flush_f !== 1'b1) begin
            tests_failed++; $display("FAIL b_flush: ds %b nds %b expected 0 1", flush_f, n_flush_f);
        end
        step();
        tests_run++;
        if (pc_f !== 32'h3004 || perf_redirect !== 32'd1) begin
            tests_failed++; $display("FAIL b_taken: pc %h cnt %0d expected 00003004 1", pc_f, perf_redirect);
        end
        br_taken = 1'b0;
        step();
        tests_run++;
        if (pc_f !== 32'h3008 || perf_redirect !== 32'd1) begin
            tests_failed++; $display("FAIL b_not_taken: pc %h cnt %0d expected 00003008 1", pc_f, perf_redirect);
        end
    endtask

    task automatic test_jal_jret();
        npc_op = 3'd3; pc_d = 32'h3010; imm26 = 26'h0000C10;
        #1;
        tests_run++;
        if (link_d !== 32'h3018) begin
            tests_failed++; $display("FAIL jal_link: got %h expected %h", link_d, 32'h3018);
        end
        step();
        tests_run++;
        if (pc_f !== 32'h3040 || ras_count !== 3'd1) begin
            tests_failed++; $display("FAIL jal: pc %h count %0d expected 00003040 1", pc_f, ras_count);
        end
        npc_op = 3'd5; jreg = 32'h3018;
        step();
        tests_run++;
        if (pc_f !== 32'h3018 || ras_count !== 3'd0 || ras_mispredict !== 1'b0 || perf_ras_miss !== 32'd0) begin
            tests_failed++; $display("FAIL jret_hit: pc %h count %0d mis %b miss %0d expected 00003018 0 0 0",
                                     pc_f, ras_count, ras_mispredict, perf_ras_miss);
        end
        tests_run++;
        if (perf_redirect !== 32'd3) begin
            tests_failed++; $display("FAIL jal_jret_count: got %0d expected 3", perf_redirect);
        end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] links [5];
        logic [2:0]  exp_cnt;
        for (int i = 0; i < 5; i++) links[i] = 32'h5008 + 32'(i) * 32'h10;
        npc_op = 3'd3; imm26 = 26'h0001000;
        for (int i = 0; i < 5; i++) begin
            pc_d = 32'h5000 + 32'(i) * 32'h10;
            step();
            exp_cnt = (i >= 3) ? 3'd4 : 3'(i + 1);
            tests_run++;
            if (ras_count !== exp_cnt) begin
                tests_failed++; $display("FAIL ras_push[%0d]: count %0d expected %0d", i, ras_count, exp_cnt);
            end
        end
        npc_op = 3'd5;
        for (int i = 4; i >= 1; i--) begin
            jreg = links[i];
            step();
            tests_run++;
            if (ras_mispredict !== 1'b0 || pc_f !== links[i]) begin
                tests_failed++; $display("FAIL ras_pop[%0d]: mis %b pc %h expected 0 %h", i, ras_mispredict, pc_f, links[i]);
            end
        end
        jreg = links[0];
        step();
        tests_run++;
        if (ras_mispredict !== 1'b1 || perf_ras_miss !== 32'd1 || ras_count !== 3'd0) begin
            tests_failed++; $display("FAIL ras_empty_miss: mis %b miss %0d count %0d expected 1 1 0",
                                     ras_mispredict, perf_ras_miss, ras_count);
        end
        npc_op = 3'd0;
        step();
        tests_run++;
        if (ras_mispredict !== 1'b0 || pc_f !== 32'h500C || perf_redirect !== 32'd13) begin
            tests_failed++; $display("FAIL ras_pulse_end: mis %b pc %h redir %0d expected 0 0000500c 13",
                                     ras_mispredict, pc_f, perf_redirect);
        end
    endtask

    task automatic test_stall_exc();
        stall = 1'b1; npc_op = 3'd2; imm26 = 26'h0000100; pc_d = 32'h6000;
        #1;
        tests_run++;
        if (flush_f !== 1'b0 || n_flush_f !== 1'b0) begin
            tests_failed++; $display("FAIL stall_flush: ds %b nds %b expected 0 0", flush_f, n_flush_f);
        end
        step();
        tests_run++;
        if (pc_f !== 32'h500C || perf_redirect !== 32'd13) begin
            tests_failed++; $display("FAIL stall_hold: pc %h redir %0d expected 0000500c 13", pc_f, perf_redirect);
        end
        exc_req = 1'b1;
        #1;
        tests_run++;
        if (flush_f !== 1'b1) begin
            tests_failed++; $display("FAIL exc_flush: got %b expected 1", flush_f);
        end
        step();
        tests_run++;
        if (pc_f !== 32'h4180 || perf_redirect !== 32'd13) begin
            tests_failed++; $display("FAIL exc_vector: pc %h redir %0d expected 00004180 13", pc_f, perf_redirect);
        end
        stall = 1'b0; exc_req = 1'b0; npc_op = 3'd0;
    endtask

    task automatic test_eret_adel();
        eret = 1'b1; epc = 32'h3100;
        #1;
        tests_run++;
        if (flush_f !== 1'b1) begin
            tests_failed++; $display("FAIL eret_flush: got %b expected 1", flush_f);
        end
        step();
        tests_run++;
        if (pc_f !== 32'h3100 || adel_f !== 1'b0) begin
            tests_failed++; $display("FAIL eret_pc: pc %h adel %b expected 00003100 0", pc_f, adel_f);
        end
        eret = 1'b0; npc_op = 3'd4; jreg = 32'h3002;
        #1;
        tests_run++;
        if (flush_f !== 1'b0 || n_flush_f !== 1'b1) begin
            tests_failed++; $display("FAIL jr_flush: ds %b nds %b expected 0 1", flush_f, n_flush_f);
        end
        step();
        tests_run++;
        if (pc_f !== 32'h3002 || adel_f !== 1'b1 || perf_redirect !== 32'd14) begin
            tests_failed++; $display("FAIL jr_adel: pc %h adel %b redir %0d expected 00003002 1 14",
                                     pc_f, adel_f, perf_redirect);
        end
        npc_op = 3'd0;
        step();
        tests_run++;
        if (pc_f !== 32'h3006 || adel_f !== 1'b1) begin
            tests_failed++; $display("FAIL misaligned_seq: pc %h adel %b expected 00003006 1", pc_f, adel_f);
        end
    endtask

    task automatic test_exc_eret_and_reset();
        exc_req = 1'b1; eret = 1'b1; epc = 32'h7000; npc_op = 3'd3; pc_d = 32'h3200;
        step();
        tests_run++;
        if (pc_f !== 32'h4180 || ras_count !== 3'd0) begin
            tests_failed++; $display("FAIL exc_over_eret: pc %h count %0d expected 00004180 0", pc_f, ras_count);
        end
        exc_req = 1'b0; eret = 1'b0;
        step();
        tests_run++;
        if (ras_count !== 3'd1) begin
            tests_failed++; $display("FAIL jal_after_exc: count %0d expected 1", ras_count);
        end
        reset = 1'b1;
        step();
        tests_run++;
        if (pc_f !== 32'h3000 || ras_count !== 3'd0 || perf_redirect !== 32'd0 || perf_ras_miss !== 32'd0) begin
            tests_failed++; $display("FAIL mid_reset: pc %h count %0d redir %0d miss %0d expected 00003000 0 0 0",
                                     pc_f, ras_count, perf_redirect, perf_ras_miss);
        end
        reset = 1'b0; npc_op = 3'd0;
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jal_jret();
        test_ras_overflow();
        test_stall_exc();
        test_eret_adel();
        test_exc_eret_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
